// File: rtl/seq_1011_pkg.sv
// Shared definitions for the 1011 serial sequence detector.
//   STATE_W  width of the state encoding
//   PATTERN  the bit sequence being detected, oldest bit in the MSB
//   state_t  3-bit binary state encoding, S0..S4 (codes 101..111 are illegal)
package seq_1011_pkg;

  localparam int STATE_W = 3;

  localparam logic [3:0] PATTERN = 4'b1011;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'b000,  // idle
    S1 = 3'b001,  // seen 1
    S2 = 3'b010,  // seen 10
    S3 = 3'b011,  // seen 101
    S4 = 3'b100   // seen 1011
  } state_t;

endpackage

// File: rtl/seq_1011_next_state.sv
// Next-state logic for the 1011 detector.
// Configuration macro: SEQ1011_STRUCT_EN
//   defined   -> gate-level sum-of-products equations on the state bits and x
//   undefined -> behavioural case statement over the enumerated states
// Both forms send every illegal code (101..111) to S0.
// Ports:
//   state       input  STATE_W  current state code
//   x           input  1        serial data bit
//   next_state  output STATE_W  state to load on the next rising edge
module seq_1011_next_state
  import seq_1011_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               x,
  output logic [STATE_W-1:0] next_state
);

`ifdef SEQ1011_STRUCT_EN

  logic s2_s;
  logic s1_s;
  logic s0_s;

  assign s2_s = state[2];
  assign s1_s = state[1];
  assign s0_s = state[0];

  // Only S3 with x=1 reaches S4.
  assign next_state[2] = ~s2_s & s1_s & s0_s & x;

  // S1/S3 with x=0 -> S2/S2, S4 with x=0 -> S2, S2 with x=1 -> S3.
  assign next_state[1] = (~x & ~s2_s & s0_s)
                       | (~x &  s2_s & ~s1_s & ~s0_s)
                       | ( x & ~s2_s &  s1_s & ~s0_s);

  // x=1 from S0, S1, S2 and S4 lands in an odd state (S1 or S3).
  assign next_state[0] = ( x & ~s2_s & ~s1_s)
                       | ( x & ~s2_s & ~s0_s)
                       | ( x &  s2_s & ~s1_s & ~s0_s);

`else

  // Each state checks x against the next expected pattern bit; a miss falls
  // back to the longest prefix of 1011 that is still a suffix of the input.
  always_comb begin
    next_state = S0;
    case (state)
      S0: begin
        if (x == PATTERN[3]) next_state = S1;
        else                 next_state = S0;
      end
      S1: begin
        if (x == PATTERN[2]) next_state = S2;
        else                 next_state = S1;
      end
      S2: begin
        if (x == PATTERN[1]) next_state = S3;
        else                 next_state = S0;
      end
      S3: begin
        if (x == PATTERN[0]) next_state = S4;
        else                 next_state = S2;
      end
      S4: begin
        // Overlap: the trailing 1 of the match starts a new candidate.
        if (x) next_state = S1;
        else   next_state = S2;
      end
      default: next_state = S0;
    endcase
  end

`endif

endmodule

// File: rtl/seq_1011_detector.sv
// Serial 1011 sequence detector (Moore) with overlapping matches and a
// saturating match counter.
// Configuration macro: SEQ1011_STRUCT_EN selects the structural next-state
// equations inside seq_1011_next_state; the default build is behavioural.
// Ports:
//   clk        input  1      clock, rising edge
//   rst        input  1      asynchronous active-high reset
//   x          input  1      serial data bit
//   detect     output 1      high for one cycle while in S4
//   state_o    output 3      current state code
//   det_count  output CNT_W  detections since reset, saturating at all-ones
module seq_1011_detector
  import seq_1011_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  output logic               detect,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   det_count
);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] next_state_s;
  logic               detect_r;
  logic [CNT_W-1:0]   count_r;
  logic               enter_s4_s;

  seq_1011_next_state u_next_state (
    .state      (state_r),
    .x          (x),
    .next_state (next_state_s)
  );

  // S4 has no self-loop, so every cycle whose next state is S4 is a new entry.
  assign enter_s4_s = (next_state_s == S4);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S0;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Detect flop tracks (state == S4) in the same cycle as the state register,
  // so the output is registered rather than decoded combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      detect_r <= 1'b0;
    end else begin
      detect_r <= enter_s4_s;
    end
  end

  // Saturating match counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enter_s4_s && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign detect    = detect_r;
  assign state_o   = state_r;
  assign det_count = count_r;

endmodule

// File: tb/tb_seq_1011_detector.sv
// Self-checking bench for seq_1011_detector: directed vector table, hand-written
// corner sequences (async reset mid-pattern, counter saturation) and a random
// stream checked against a suffix-matching reference model.
module tb_seq_1011_detector;

  logic       clk;
  logic       rst;
  logic       x;
  logic       detect;
  logic [2:0] state_o;
  logic [7:0] det_count;
  logic       detect2;
  logic [2:0] state_o2;
  logic [1:0] det_count2;

  int n_checks;
  int n_fail;

  seq_1011_detector #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .detect    (detect),
    .state_o   (state_o),
    .det_count (det_count)
  );

  seq_1011_detector #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .detect    (detect2),
    .state_o   (state_o2),
    .det_count (det_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       r;
    logic       b;
    logic       exp_det;
    logic [2:0] exp_state;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one bit: inputs change on the falling edge, outputs are sampled 1 after the rising edge.
  task automatic step(input logic r, input logic b);
    @(negedge clk);
    rst = r;
    x   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic b, input logic d, input logic [2:0] s, input int c);
    vec_t v;
    v.r = r; v.b = b; v.exp_det = d; v.exp_state = s; v.exp_cnt = c;
    vecs.push_back(v);
  endtask

  function automatic int sat(input int c, input int maxv);
    return (c > maxv) ? maxv : c;
  endfunction

  // Reference: state = longest prefix of 1011 that is a suffix of the bits since reset.
  function automatic logic [2:0] model_state(input logic [3:0] h, input int nb);
    if (nb >= 4 && h == 4'b1011)      return 3'b100;
    if (nb >= 3 && h[2:0] == 3'b101)  return 3'b011;
    if (nb >= 2 && h[1:0] == 2'b10)   return 3'b010;
    if (nb >= 1 && h[0] == 1'b1)      return 3'b001;
    return 3'b000;
  endfunction

  initial begin
    logic [3:0] hist;
    int         nb;
    int         cnt;
    logic [2:0] es;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    x   = 1'b0;

    // Reset for 2 cycles with x toggling.
    add(1'b1, 1'b1, 1'b0, 3'b000, 0);
    add(1'b1, 1'b0, 1'b0, 3'b000, 0);
    // 1,0,1,1
    add(1'b0, 1'b1, 1'b0, 3'b001, 0);
    add(1'b0, 1'b0, 1'b0, 3'b010, 0);
    add(1'b0, 1'b1, 1'b0, 3'b011, 0);
    add(1'b0, 1'b1, 1'b1, 3'b100, 1);
    // 1,0,1,1,0,1,0,1,1,0 after reset
    add(1'b1, 1'b0, 1'b0, 3'b000, 0);
    add(1'b0, 1'b1, 1'b0, 3'b001, 0);
    add(1'b0, 1'b0, 1'b0, 3'b010, 0);
    add(1'b0, 1'b1, 1'b0, 3'b011, 0);
    add(1'b0, 1'b1, 1'b1, 3'b100, 1);
    add(1'b0, 1'b0, 1'b0, 3'b010, 1);
    add(1'b0, 1'b1, 1'b0, 3'b011, 1);
    add(1'b0, 1'b0, 1'b0, 3'b010, 1);
    add(1'b0, 1'b1, 1'b0, 3'b011, 1);
    add(1'b0, 1'b1, 1'b1, 3'b100, 2);
    add(1'b0, 1'b0, 1'b0, 3'b010, 2);
    // Overlap 1,0,1,1,0,1,1 after reset
    add(1'b1, 1'b0, 1'b0, 3'b000, 0);
    add(1'b0, 1'b1, 1'b0, 3'b001, 0);
    add(1'b0, 1'b0, 1'b0, 3'b010, 0);
    add(1'b0, 1'b1, 1'b0, 3'b011, 0);
    add(1'b0, 1'b1, 1'b1, 3'b100, 1);
    add(1'b0, 1'b0, 1'b0, 3'b010, 1);
    add(1'b0, 1'b1, 1'b0, 3'b011, 1);
    add(1'b0, 1'b1, 1'b1, 3'b100, 2);
    // Near misses 1,0,0,1,1 then 1,1,1,1 after reset
    add(1'b1, 1'b0, 1'b0, 3'b000, 0);
    add(1'b0, 1'b1, 1'b0, 3'b001, 0);
    add(1'b0, 1'b0, 1'b0, 3'b010, 0);
    add(1'b0, 1'b0, 1'b0, 3'b000, 0);
    add(1'b0, 1'b1, 1'b0, 3'b001, 0);
    add(1'b0, 1'b1, 1'b0, 3'b001, 0);
    add(1'b1, 1'b1, 1'b0, 3'b000, 0);
    add(1'b0, 1'b1, 1'b0, 3'b001, 0);
    add(1'b0, 1'b1, 1'b0, 3'b001, 0);
    add(1'b0, 1'b1, 1'b0, 3'b001, 0);
    add(1'b0, 1'b1, 1'b0, 3'b001, 0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].b);
      chk($sformatf("vec%0d_detect", i), {31'd0, detect}, {31'd0, vecs[i].exp_det});
      chk($sformatf("vec%0d_state", i), {29'd0, state_o}, {29'd0, vecs[i].exp_state});
      chk($sformatf("vec%0d_count", i), {24'd0, det_count}, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_count2", i), {30'd0, det_count2}, sat(vecs[i].exp_cnt, 3));
    end

    // Asynchronous reset between bits 3 and 4 of 1,0,1,1.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("async_pre_state", {29'd0, state_o}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_state_now", {29'd0, state_o}, 32'd0);
    chk("async_detect_now", {31'd0, detect}, 32'd0);
    step(1'b0, 1'b1);
    chk("async_after_state", {29'd0, state_o}, 32'd1);
    chk("async_after_detect", {31'd0, detect}, 32'd0);
    chk("async_after_count", {24'd0, det_count}, 32'd0);

    // Five back-to-back 1011 patterns: 8-bit counter reads 5, 2-bit saturates at 3.
    step(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk($sformatf("sat_detect%0d", k), {31'd0, detect2}, 32'd1);
    end
    chk("sat_count8", {24'd0, det_count}, 32'd5);
    chk("sat_count2", {30'd0, det_count2}, 32'd3);
    step(1'b0, 1'b0);
    chk("sat_hold_detect", {31'd0, detect2}, 32'd0);

    // Random stream against the suffix model.
    step(1'b1, 1'b0);
    hist = 4'b0000;
    nb   = 0;
    cnt  = 0;
    for (int k = 0; k < 1000; k++) begin
      logic b;
      b = 1'($urandom_range(1, 0));
      step(1'b0, b);
      hist = {hist[2:0], b};
      if (nb < 4) nb++;
      es = model_state(hist, nb);
      if (es == 3'b100) cnt++;
      chk("rand_state", {29'd0, state_o}, {29'd0, es});
      chk("rand_detect", {31'd0, detect}, {31'd0, (es == 3'b100)});
      chk("rand_count", {24'd0, det_count}, sat(cnt, 255));
      chk("rand_count2", {30'd0, det_count2}, sat(cnt, 3));
      chk("rand_state2", {29'd0, state_o2}, {29'd0, es});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
